// File: rtl/trigger_buffer.sv
// Oscilloscope-style capture buffer: stores pre-trigger history in a circular RAM,
// waits for a level crossing (or forced trigger), fills the post-trigger window, then streams it out.
module trigger_buffer #(
    parameter int DATA_WIDTH          = 8,
    parameter int ADDR_WIDTH          = 8,
    parameter int REG_DATA_WIDTH      = 16,
    parameter int REG_ADDR_WIDTH      = 8,
    parameter int REG_ADDR_CTRL       = 3,
    parameter int REG_ADDR_TRIG_LEVEL = 4,
    parameter int REG_ADDR_PRETRIG    = 5
) (
    input  logic                      clk_i,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_rdy,
    input  logic [REG_DATA_WIDTH-1:0] reg_si_data,
    input  logic [REG_ADDR_WIDTH-1:0] reg_si_addr,
    input  logic                      reg_si_rdy,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_rdy,
    input  logic                      out_ack,
    output logic                      triggered,
    output logic                      busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [REG_ADDR_WIDTH-1:0] A_CTRL = REG_ADDR_CTRL[REG_ADDR_WIDTH-1:0];
    localparam logic [REG_ADDR_WIDTH-1:0] A_LVL  = REG_ADDR_TRIG_LEVEL[REG_ADDR_WIDTH-1:0];
    localparam logic [REG_ADDR_WIDTH-1:0] A_PRE  = REG_ADDR_PRETRIG[REG_ADDR_WIDTH-1:0];

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic                    triggered_q, triggered_d;
    logic [DATA_WIDTH-1:0]   prev_q, prev_d;
    logic                    prev_vld_q, prev_vld_d;
    logic [DATA_WIDTH-1:0]   trig_level_q, trig_level_d;
    logic [ADDR_WIDTH-1:0]   pretrig_q, pretrig_d;
    logic                    edge_q, edge_d;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic                    out_rdy_q, busy_q;
    logic [DATA_WIDTH-1:0]   buf_q [DEPTH];

    logic                    ctrl_wr_s, start_s, force_s, abort_s, hit_s, wr_en_s;
    logic [ADDR_WIDTH:0]     post_len_s;
    logic                    unused_reg_bits_s;

    assign unused_reg_bits_s = ^reg_si_data;

    // Register-bus decode and configuration register next values
    always_comb begin
        ctrl_wr_s    = reg_si_rdy && (reg_si_addr == A_CTRL);
        start_s      = ctrl_wr_s && reg_si_data[0];
        force_s      = ctrl_wr_s && reg_si_data[2];
        abort_s      = ctrl_wr_s && reg_si_data[3];
        edge_d       = ctrl_wr_s ? reg_si_data[1] : edge_q;
        trig_level_d = (reg_si_rdy && (reg_si_addr == A_LVL)) ? reg_si_data[DATA_WIDTH-1:0] : trig_level_q;
        pretrig_d    = (reg_si_rdy && (reg_si_addr == A_PRE)) ? reg_si_data[ADDR_WIDTH-1:0] : pretrig_q;
        post_len_s   = DEPTH_C - {1'b0, pretrig_q};
        if (!prev_vld_q) begin
            hit_s = 1'b0;
        end else if (edge_q) begin
            hit_s = (prev_q > trig_level_q) && (in_data <= trig_level_q);
        end else begin
            hit_s = (prev_q < trig_level_q) && (in_data >= trig_level_q);
        end
    end

    // Capture/readout state machine: next state, pointers, counters
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        triggered_d = triggered_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        wr_en_s     = 1'b0;
        if (abort_s) begin
            state_d     = S_IDLE;
            triggered_d = 1'b0;
            prev_vld_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_s) begin
                        wr_ptr_d    = {ADDR_WIDTH{1'b0}};
                        cnt_d       = {(ADDR_WIDTH+1){1'b0}};
                        triggered_d = 1'b0;
                        prev_vld_d  = 1'b0;
                        state_d     = (pretrig_q == {ADDR_WIDTH{1'b0}}) ? S_ARMED : S_PRE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PRE: begin
                    if (in_rdy) begin
                        wr_en_s = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = (cnt_d >= {1'b0, pretrig_q}) ? S_ARMED : S_PRE;
                    end else begin
                        state_d = S_PRE;
                    end
                end
                S_ARMED: begin
                    wr_en_s = in_rdy;
                    // A forced trigger without a sample still opens the post window, just one sample shorter in hand
                    if (force_s || (in_rdy && hit_s)) begin
                        triggered_d = 1'b1;
                        cnt_d       = {{ADDR_WIDTH{1'b0}}, in_rdy};
                        state_d     = (cnt_d == post_len_s) ? S_READ : S_POST;
                    end else begin
                        state_d = S_ARMED;
                    end
                end
                S_POST: begin
                    if (in_rdy) begin
                        wr_en_s = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = (cnt_d == post_len_s) ? S_READ : S_POST;
                    end else begin
                        state_d = S_POST;
                    end
                end
                S_READ: begin
                    if (out_ack) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                        state_d  = (cnt_d == DEPTH_C) ? S_IDLE : S_READ;
                    end else begin
                        state_d = S_READ;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
            if (wr_en_s) begin
                wr_ptr_d   = wr_ptr_q + 1'b1;
                prev_d     = in_data;
                prev_vld_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_d;
            end
            // Readout starts at the oldest sample, which is the slot the next write would overwrite
            if ((state_q != S_READ) && (state_d == S_READ)) begin
                rd_ptr_d = wr_ptr_d;
                cnt_d    = {(ADDR_WIDTH+1){1'b0}};
            end else begin
                rd_ptr_d = rd_ptr_d;
            end
        end
    end

    // State, configuration and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= {ADDR_WIDTH{1'b0}};
            rd_ptr_q     <= {ADDR_WIDTH{1'b0}};
            cnt_q        <= {(ADDR_WIDTH+1){1'b0}};
            triggered_q  <= 1'b0;
            prev_q       <= {DATA_WIDTH{1'b0}};
            prev_vld_q   <= 1'b0;
            trig_level_q <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
            pretrig_q    <= {1'b1, {(ADDR_WIDTH-1){1'b0}}};
            edge_q       <= 1'b0;
            out_data_q   <= {DATA_WIDTH{1'b0}};
            out_rdy_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            triggered_q  <= triggered_d;
            prev_q       <= prev_d;
            prev_vld_q   <= prev_vld_d;
            trig_level_q <= trig_level_d;
            pretrig_q    <= pretrig_d;
            edge_q       <= edge_d;
            out_data_q   <= (state_d == S_READ) ? buf_q[rd_ptr_d] : {DATA_WIDTH{1'b0}};
            out_rdy_q    <= (state_d == S_READ);
            busy_q       <= (state_d != S_IDLE);
        end
    end

    // Sample RAM; deliberately not reset
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            buf_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_data  = out_data_q;
    assign out_rdy   = out_rdy_q;
    assign triggered = triggered_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_trigger_buffer.sv
// Randomized and directed bench for trigger_buffer, checked every cycle against a
// queue-based reference model of the capture window.
module tb_trigger_buffer;

    localparam int DEPTH = 256;

    logic        clk_i = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_rdy = 1'b0;
    logic [15:0] reg_si_data = 16'd0;
    logic [7:0]  reg_si_addr = 8'd0;
    logic        reg_si_rdy = 1'b0;
    logic [7:0]  out_data;
    logic        out_rdy;
    logic        out_ack = 1'b0;
    logic        triggered;
    logic        busy;

    always #5 clk_i = ~clk_i;

    trigger_buffer dut (
        .clk_i(clk_i), .rst(rst), .in_data(in_data), .in_rdy(in_rdy),
        .reg_si_data(reg_si_data), .reg_si_addr(reg_si_addr), .reg_si_rdy(reg_si_rdy),
        .out_data(out_data), .out_rdy(out_rdy), .out_ack(out_ack),
        .triggered(triggered), .busy(busy)
    );

    int n_chk = 0;
    int n_err = 0;

    // reference model: phase 0 idle, 1 pre, 2 armed, 3 post, 4 read
    int         m_phase = 0;
    int         pre_left, post_left;
    logic [7:0] m_lvl = 8'h80;
    int         m_pretrig = 128;
    bit         m_edge = 1'b0;
    bit         m_trig = 1'b0;
    bit         m_pv = 1'b0;
    logic [7:0] m_prev = 8'd0;
    logic [7:0] cap[$];
    logic [7:0] rdq[$];

    logic [7:0] got[DEPTH];
    int         n_got;
    logic [7:0] ramp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit crosses(input logic [7:0] p, input logic [7:0] c);
        if (m_edge) return (p > m_lvl) && (c <= m_lvl);
        return (p < m_lvl) && (c >= m_lvl);
    endfunction

    task automatic take(input logic [7:0] d);
        cap.push_back(d);
        m_prev = d;
        m_pv   = 1'b1;
    endtask

    task automatic to_read();
        int sz = cap.size();
        rdq.delete();
        for (int i = sz - DEPTH; i < sz; i++) if (i >= 0) rdq.push_back(cap[i]);
        m_phase = 4;
    endtask

    task automatic model_tick(input bit r, input bit iv, input logic [7:0] d, input bit rv,
                              input logic [7:0] ra, input logic [15:0] rd, input bit ack);
        bit is_ctrl, st, fc, ab, fire;
        logic [7:0] nlvl;
        int npre;
        bit nedge;
        if (r) begin
            m_phase = 0; m_lvl = 8'h80; m_pretrig = 128; m_edge = 1'b0;
            m_trig = 1'b0; m_pv = 1'b0; m_prev = 8'd0; rdq.delete(); cap.delete();
            return;
        end
        is_ctrl = rv && (ra == 8'd3);
        st = is_ctrl && rd[0];
        fc = is_ctrl && rd[2];
        ab = is_ctrl && rd[3];
        nlvl = (rv && ra == 8'd4) ? rd[7:0] : m_lvl;
        npre = (rv && ra == 8'd5) ? int'(rd[7:0]) : m_pretrig;
        nedge = is_ctrl ? rd[1] : m_edge;
        if (ab) begin
            m_phase = 0; m_trig = 1'b0; m_pv = 1'b0; rdq.delete();
        end else begin
            case (m_phase)
                0: if (st) begin
                    m_trig = 1'b0; m_pv = 1'b0; cap.delete();
                    if (m_pretrig == 0) m_phase = 2;
                    else begin pre_left = m_pretrig; m_phase = 1; end
                end
                1: if (iv) begin
                    take(d);
                    pre_left--;
                    if (pre_left == 0) m_phase = 2;
                end
                2: begin
                    fire = fc || (iv && m_pv && crosses(m_prev, d));
                    if (iv) take(d);
                    if (fire) begin
                        m_trig = 1'b1;
                        post_left = DEPTH - m_pretrig - (iv ? 1 : 0);
                        if (post_left == 0) to_read();
                        else m_phase = 3;
                    end
                end
                3: if (iv) begin
                    take(d);
                    post_left--;
                    if (post_left == 0) to_read();
                end
                4: if (ack) begin
                    void'(rdq.pop_front());
                    if (rdq.size() == 0) m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end
        m_lvl = nlvl; m_pretrig = npre; m_edge = nedge;
    endtask

    // one clock: drive at negedge, advance model at posedge, compare at next negedge
    task automatic step(input bit r, input bit iv, input logic [7:0] id, input bit rv,
                        input logic [7:0] ra, input logic [15:0] rdat, input bit ack);
        logic [7:0] exp_d;
        rst = r; in_rdy = iv; in_data = id; reg_si_rdy = rv;
        reg_si_addr = ra; reg_si_data = rdat; out_ack = ack;
        @(posedge clk_i);
        model_tick(r, iv, id, rv, ra, rdat, ack);
        @(negedge clk_i);
        exp_d = (m_phase == 4 && rdq.size() > 0) ? rdq[0] : 8'd0;
        chk("out_rdy", {31'd0, out_rdy}, {31'd0, m_phase == 4});
        chk("busy", {31'd0, busy}, {31'd0, m_phase != 0});
        chk("triggered", {31'd0, triggered}, {31'd0, m_trig});
        chk("out_data", {24'd0, out_data}, {24'd0, exp_d});
    endtask

    task automatic wreg(input logic [7:0] a, input logic [15:0] d);
        step(1'b0, 1'b0, 8'd0, 1'b1, a, d, 1'b0);
    endtask

    task automatic feed_ramp(input bit down);
        for (int c = 0; c < 3000 && (m_phase == 1 || m_phase == 2 || m_phase == 3); c++) begin
            step(1'b0, 1'b1, ramp, 1'b0, 8'd0, 16'd0, 1'b0);
            ramp = down ? ramp - 8'd1 : ramp + 8'd1;
        end
        chk("capture_done", m_phase, 4);
    endtask

    // period 0 means random acks; poke issues a start write during readout
    task automatic readout(input int period, input bit poke);
        bit a;
        n_got = 0;
        for (int c = 0; c < 4000 && m_phase == 4; c++) begin
            a = (period == 0) ? bit'($urandom_range(0, 1)) : ((c % period) == period - 1);
            if (a && out_rdy && n_got < DEPTH) begin
                got[n_got] = out_data;
                n_got++;
            end
            if (poke && c == 7) step(1'b0, 1'b0, 8'd0, 1'b1, 8'd3, 16'h0001, a);
            else step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 16'd0, a);
        end
        chk("read_done", m_phase, 0);
        chk("ack_count", n_got, DEPTH);
    endtask

    initial begin
        @(negedge clk_i);
        step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 16'd0, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0, 8'd0, 16'd0, 1'b1);
        step(1'b0, 1'b1, 8'h55, 1'b0, 8'd0, 16'd0, 1'b1);

        // rising ramp with default settings, ack every 3rd cycle
        wreg(8'd3, 16'h0001);
        ramp = 8'd0;
        feed_ramp(1'b0);
        readout(3, 1'b0);
        chk("ramp_idx0", got[0], 8'h00);
        chk("ramp_idx127", got[127], 8'h7F);
        chk("ramp_idx128", got[128], 8'h80);
        chk("ramp_idx255", got[255], 8'hFF);
        step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 16'd0, 1'b1);
        step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 16'd0, 1'b1);

        // falling edge, level 0x40, no pretrigger, descending ramp
        wreg(8'd4, 16'h0040);
        wreg(8'd5, 16'h0000);
        wreg(8'd3, 16'h0003);
        ramp = 8'hFF;
        feed_ramp(1'b1);
        readout(1, 1'b0);
        chk("fall_first", got[0], 8'h40);
        chk("fall_second", got[1], 8'h3F);
        chk("fall_last", got[255], 8'h41);

        // constant input with forced trigger
        wreg(8'd3, 16'h0000);
        wreg(8'd4, 16'h0080);
        wreg(8'd5, 16'h0080);
        wreg(8'd3, 16'h0001);
        for (int c = 0; c < 300 && m_phase != 2; c++) step(1'b0, 1'b1, 8'h10, 1'b0, 8'd0, 16'd0, 1'b0);
        for (int c = 0; c < 5; c++) step(1'b0, 1'b1, 8'h10, 1'b0, 8'd0, 16'd0, 1'b0);
        step(1'b0, 1'b1, 8'h10, 1'b1, 8'd3, 16'h0004, 1'b0);
        chk("force_trig", {31'd0, triggered}, 32'd1);
        ramp = 8'h10;
        for (int c = 0; c < 300 && m_phase == 3; c++) step(1'b0, 1'b1, 8'h10, 1'b0, 8'd0, 16'd0, 1'b0);
        chk("force_capture", m_phase, 4);
        readout(2, 1'b0);
        for (int i = 0; i < DEPTH; i += 17) chk("force_const", got[i], 8'h10);

        // abort while armed, abort+start together, then a clean capture
        wreg(8'd3, 16'h0001);
        for (int c = 0; c < 300 && m_phase != 2; c++) step(1'b0, 1'b1, 8'h05, 1'b0, 8'd0, 16'd0, 1'b0);
        step(1'b0, 1'b1, 8'h06, 1'b0, 8'd0, 16'd0, 1'b0);
        step(1'b0, 1'b1, 8'h07, 1'b1, 8'd3, 16'h0008, 1'b0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_rdy", {31'd0, out_rdy}, 32'd0);
        wreg(8'd3, 16'h0009);
        chk("abort_wins", {31'd0, busy}, 32'd0);
        wreg(8'd3, 16'h0001);
        ramp = 8'd0;
        feed_ramp(1'b0);
        readout(0, 1'b0);
        chk("abort_recap", got[128], 8'h80);

        // reset in the middle of readout
        wreg(8'd3, 16'h0001);
        ramp = 8'd0;
        feed_ramp(1'b0);
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 16'd0, 1'b1);
        step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 16'd0, 1'b0);
        chk("rst_rdy", {31'd0, out_rdy}, 32'd0);
        chk("rst_trig", {31'd0, triggered}, 32'd0);
        wreg(8'd3, 16'h0001);
        ramp = 8'd0;
        feed_ramp(1'b0);
        readout(1, 1'b0);
        chk("rst_recap", got[0], 8'h00);

        // pretrigger 255: one-sample post window, start during readout ignored
        wreg(8'd5, 16'h00FF);
        wreg(8'd3, 16'h0001);
        ramp = 8'd0;
        feed_ramp(1'b0);
        chk("p255_rdy", {31'd0, out_rdy}, 32'd1);
        chk("p255_trig", {31'd0, triggered}, 32'd1);
        readout(2, 1'b1);
        chk("p255_first", got[0], 8'h81);
        chk("p255_last", got[255], 8'h80);

        // randomized captures
        for (int k = 0; k < 6; k++) begin
            int armed_cyc;
            bit iv, rv;
            logic [7:0] ra;
            logic [15:0] rd;
            wreg(8'd4, 16'($urandom_range(1, 254)));
            wreg(8'd5, 16'($urandom_range(0, 255)));
            wreg(8'd3, {14'd0, 1'($urandom_range(0, 1)), 1'b1});
            armed_cyc = 0;
            for (int c = 0; c < 3000 && m_phase != 0 && m_phase != 4; c++) begin
                iv = ($urandom_range(0, 3) != 0);
                rv = 1'b0; ra = 8'd0; rd = 16'd0;
                if (m_phase == 2) armed_cyc++;
                if ($urandom_range(0, 63) == 0) begin
                    rv = 1'b1; ra = 8'd3; rd = {13'd0, 1'b1, 1'($urandom_range(0, 1)), 1'b0};
                end else if ($urandom_range(0, 49) == 0) begin
                    rv = 1'b1; ra = 8'd4; rd = 16'($urandom_range(0, 255));
                end else if (armed_cyc > 100) begin
                    rv = 1'b1; ra = 8'd3; rd = {13'd0, 1'b1, m_edge, 1'b0};
                end
                step(1'b0, iv, 8'($urandom_range(0, 255)), rv, ra, rd, 1'($urandom_range(0, 1)));
            end
            chk("rand_capture", m_phase, 4);
            readout(0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
